// File: rtl/stack_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_pkg
// Brief    : Shared encodings for the stack/data memory controller.
// Revision : 1.0  initial release
// ============================================================================
package stack_mem_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PEEK = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    localparam int F_OVF   = 0;
    localparam int F_UNF   = 1;
    localparam int F_MISAL = 2;
    localparam int F_CONFL = 3;

endpackage
`default_nettype wire

// File: rtl/stack_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_ram
// Brief    : Single-port DEPTH x DATA_W RAM, byte write enables, registered read.
// Revision : 1.0  initial release
// ============================================================================
module stack_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic [DATA_W/8-1:0]        we,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) begin
                r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            r_q <= r_mem[addr];
        end
    end

    assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem_ctrl
// Brief    : Windowed stack/data memory with push/pop/peek, mapped access, faults.
// Revision : 1.0  initial release
// ============================================================================
module stack_mem_ctrl
    import stack_mem_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [1:0]            stack_op,
    input  logic                  update_sp,
    input  logic [31:0]           new_sp,
    input  logic                  clr_fault,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic [31:0]           sp,
    output logic                  full,
    output logic                  empty,
    output logic [3:0]            fault
);

    localparam int          BYTES      = DATA_W / 8;
    localparam int          ADDR_LSB   = $clog2(BYTES);
    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [31:0] WORD_BYTES = 32'(BYTES);
    localparam logic [31:0] SP_TOP     = BASE_ADDR + 32'(DEPTH * BYTES);

    logic [31:0]       r_sp;
    logic              r_rvalid;
    logic              r_haveRead;
    logic [3:0]        r_fault;

    logic              w_inWin;
    logic              w_addrAligned;
    logic              w_newSpOk;
    logic              w_memReq;
    logic              w_full;
    logic              w_empty;
    logic [IDX_W-1:0]  w_addrIdx;
    logic [IDX_W-1:0]  w_spIdx;
    logic [IDX_W-1:0]  w_pushIdx;

    logic [31:0]       w_spNext;
    logic [3:0]        w_faultSet;
    logic [BYTES-1:0]  w_ramWe;
    logic              w_ramRe;
    logic [IDX_W-1:0]  w_ramAddr;
    logic [DATA_W-1:0] w_ramQ;

    assign w_inWin       = (addr >= BASE_ADDR) && (addr < SP_TOP);
    assign w_addrAligned = (addr[ADDR_LSB-1:0] == '0);
    assign w_newSpOk     = (new_sp >= BASE_ADDR) && (new_sp <= SP_TOP) &&
                           (new_sp[ADDR_LSB-1:0] == '0);
    assign w_memReq      = mem_rd | mem_wr;
    assign w_full        = (r_sp == BASE_ADDR);
    assign w_empty       = (r_sp == SP_TOP);

    assign w_addrIdx = IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
    assign w_spIdx   = IDX_W'((r_sp - BASE_ADDR) >> ADDR_LSB);
    assign w_pushIdx = IDX_W'((r_sp - BASE_ADDR - WORD_BYTES) >> ADDR_LSB);

    // Arbitration: update_sp > stack_op > mapped access; at most one RAM access.
    always_comb begin
        w_spNext   = r_sp;
        w_faultSet = '0;
        w_ramWe    = '0;
        w_ramRe    = 1'b0;
        w_ramAddr  = w_addrIdx;

        if (update_sp) begin
            if (w_newSpOk) begin
                w_spNext = new_sp;
            end else begin
                w_faultSet[F_MISAL] = 1'b1;
            end
            if (stack_op != OP_NONE) begin
                w_faultSet[F_CONFL] = 1'b1;
            end
            if (w_memReq && w_inWin) begin
                w_faultSet[F_CONFL] = 1'b1;
            end
        end else if (stack_op != OP_NONE) begin
            if (stack_op == OP_PUSH) begin
                if (w_full) begin
                    w_faultSet[F_OVF] = 1'b1;
                end else begin
                    w_ramWe   = '1;
                    w_ramAddr = w_pushIdx;
                    w_spNext  = r_sp - WORD_BYTES;
                end
            end else begin
                if (w_empty) begin
                    w_faultSet[F_UNF] = 1'b1;
                end else begin
                    w_ramRe   = 1'b1;
                    w_ramAddr = w_spIdx;
                    if (stack_op == OP_POP) begin
                        w_spNext = r_sp + WORD_BYTES;
                    end
                end
            end
            if (w_memReq && w_inWin) begin
                w_faultSet[F_CONFL] = 1'b1;
            end
        end else if (w_memReq && w_inWin) begin
            if (!w_addrAligned) begin
                w_faultSet[F_MISAL] = 1'b1;
            end else if (mem_wr) begin
                w_ramWe = be;
                if (mem_rd) begin
                    w_faultSet[F_CONFL] = 1'b1;
                end
            end else begin
                w_ramRe = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps the RAM untouched on any edge taken during reset.
    stack_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (w_ramWe & {BYTES{rst_n}}),
        .re     (w_ramRe & rst_n),
        .addr   (w_ramAddr),
        .wdata  (wdata),
        .rdata  (w_ramQ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp       <= SP_TOP;
            r_rvalid   <= 1'b0;
            r_haveRead <= 1'b0;
            r_fault    <= '0;
        end else begin
            r_sp       <= w_spNext;
            r_rvalid   <= w_ramRe;
            r_haveRead <= r_haveRead | w_ramRe;
            r_fault    <= clr_fault ? w_faultSet : (r_fault | w_faultSet);
        end
    end

    // The RAM read register only changes on a read, so it already holds between reads.
    assign rdata  = r_haveRead ? w_ramQ : '0;
    assign rvalid = r_rvalid;
    assign sp     = r_sp;
    assign full   = w_full;
    assign empty  = w_empty;
    assign fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_mem_ctrl
// Brief    : Scoreboard bench for stack_mem_ctrl at default parameters.
// Revision : 1.0  initial release
// ============================================================================
module tb_stack_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  stack_op = 2'b00;
    logic        update_sp = 1'b0;
    logic [31:0] new_sp = '0;
    logic        clr_fault = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] sp;
    logic        full;
    logic        empty;
    logic [3:0]  fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    stack_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .stack_op  (stack_op),
        .update_sp (update_sp),
        .new_sp    (new_sp),
        .clr_fault (clr_fault),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected rdata=%08h required=no rvalid", rdata);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata actual=%08h required=%08h", rdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic idle();
        addr = '0; wdata = '0; be = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        stack_op = 2'b00; update_sp = 1'b0; new_sp = '0; clr_fault = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [31:0] d);
        stack_op = 2'b10; wdata = d; tick();
    endtask

    task automatic pop(input logic [31:0] e);
        expQ.push_back(e); stack_op = 2'b11; tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; mem_wr = 1'b1; tick();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] e);
        expQ.push_back(e); addr = a; mem_rd = 1'b1; tick();
    endtask

    task automatic clear();
        clr_fault = 1'b1; tick();
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_sp", sp, 32'h4000);
        check("reset_fault", {28'd0, fault}, 32'h0);
        check("reset_flags", {30'd0, full, empty}, 32'h1);
        check("reset_rvalid_rdata", {31'd0, rvalid} | rdata, 32'h0);

        // underflow on empty stack, then clear
        stack_op = 2'b11; tick();
        check("pop_empty_fault", {28'd0, fault}, 32'h2);
        check("pop_empty_sp", sp, 32'h4000);
        clear();
        check("clr_fault", {28'd0, fault}, 32'h0);

        // LIFO order
        push(32'h11); push(32'h22); push(32'h33);
        check("sp_after_3_push", sp, 32'h3FF4);
        pop(32'h33); pop(32'h22); pop(32'h11);
        check("sp_after_3_pop", sp, 32'h4000);
        check("empty_after_pop", {31'd0, empty}, 32'h1);
        push(32'h44); pop(32'h44);

        // overflow at full stack; RAM at base keeps its prior word
        store(32'h3000, 32'hCAFEF00D, 4'hF);
        update_sp = 1'b1; new_sp = 32'h3000; tick();
        check("sp_base", sp, 32'h3000);
        check("full_at_base", {31'd0, full}, 32'h1);
        push(32'hAA);
        check("overflow_fault", {28'd0, fault}, 32'h1);
        check("overflow_sp", sp, 32'h3000);
        load(32'h3000, 32'hCAFEF00D);
        clear();

        // update_sp suppresses a concurrent stack op; bad new_sp is rejected
        update_sp = 1'b1; new_sp = 32'h4000; stack_op = 2'b10; wdata = 32'hBAD; tick();
        check("upd_conflict_sp", sp, 32'h4000);
        check("upd_conflict_fault", {28'd0, fault}, 32'h8);
        clear();
        update_sp = 1'b1; new_sp = 32'h5000; tick();
        check("upd_bad_sp", sp, 32'h4000);
        check("upd_bad_fault", {28'd0, fault}, 32'h4);
        clear();

        // byte-enabled stores
        store(32'h3100, 32'hDEADBEEF, 4'hF);
        store(32'h3100, 32'h000000FF, 4'h1);
        load(32'h3100, 32'hDEADBEFF);

        // misaligned and out-of-window loads
        addr = 32'h3102; mem_rd = 1'b1; tick();
        check("misaligned_fault", {28'd0, fault}, 32'h4);
        clear();
        addr = 32'h2000; mem_rd = 1'b1; tick();
        addr = 32'h4000; mem_rd = 1'b1; tick();
        check("out_of_window_fault", {28'd0, fault}, 32'h0);

        // push with concurrent mapped load: push wins
        stack_op = 2'b10; wdata = 32'h55; addr = 32'h3100; mem_rd = 1'b1; tick();
        check("conflict_sp", sp, 32'h3FFC);
        check("conflict_fault", {28'd0, fault}, 32'h8);
        pop(32'h55);
        clear();

        // store+load together: store wins, no read
        addr = 32'h3104; wdata = 32'h1234; be = 4'hF; mem_wr = 1'b1; mem_rd = 1'b1; tick();
        check("rdwr_fault", {28'd0, fault}, 32'h8);
        load(32'h3104, 32'h1234);

        // set and clear in the same cycle leaves the bit set
        stack_op = 2'b11; clr_fault = 1'b1; tick();
        check("set_beats_clear", {28'd0, fault}, 32'h2);
        clear();

        // asynchronous reset mid-operation discards the pending pop and any write
        push(32'h77);
        stack_op = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_sp", sp, 32'h4000);
        check("async_reset_rvalid", {31'd0, rvalid}, 32'h0);
        stack_op = 2'b10; wdata = 32'h99;
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        load(32'h3FFC, 32'h77);

        repeat (3) tick();
        check("scoreboard_drained", expQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
